// File: rtl/seg7_pattern_reader_if.sv
// Segment-bus observation interface for seg7_pattern_reader.
// The master drives the observed display bus; the slave is the reader that
// reports the recovered digits.
// Optional macro SEG7_PATTERN_READER_DP_EN adds the decimal point signals
// dp_in and dps.
interface seg7_pattern_reader_if #(
    parameter int NUM_DIGITS = 4
);
    logic [6:0]              seg_in;
    logic [NUM_DIGITS-1:0]   dig_sel;
    logic [3:0]              valor;
    logic [2:0]              digito;
    logic                    novo;
    logic                    apagado;
    logic                    erro;
    logic [7:0]              err_count;
    logic [4*NUM_DIGITS-1:0] valores;
    logic [NUM_DIGITS-1:0]   validos;
`ifdef SEG7_PATTERN_READER_DP_EN
    logic                    dp_in;
    logic [NUM_DIGITS-1:0]   dps;

    modport master (
        output seg_in, dig_sel, dp_in,
        input  valor, digito, novo, apagado, erro, err_count, valores, validos, dps
    );
    modport slave (
        input  seg_in, dig_sel, dp_in,
        output valor, digito, novo, apagado, erro, err_count, valores, validos, dps
    );
`else
    modport master (
        output seg_in, dig_sel,
        input  valor, digito, novo, apagado, erro, err_count, valores, validos
    );
    modport slave (
        input  seg_in, dig_sel,
        output valor, digito, novo, apagado, erro, err_count, valores, validos
    );
`endif
endinterface

// File: rtl/seg7_pattern_reader.sv
// seg7_pattern_reader: watches an active-low gfedcba segment bus that is
// multiplexed across digits by a one-hot dig_sel, debounces each
// {dig_sel, segments} sample with a stability counter and decodes accepted
// patterns into per-digit hex registers, flagging blank and illegal codes.
// Optional macro SEG7_PATTERN_READER_DP_EN: the decimal point takes part in
// the stability compare and is reported per digit on dps.
module seg7_pattern_reader #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input logic                  clk,
    input logic                  reset,
    seg7_pattern_reader_if.slave bus
);

`ifdef SEG7_PATTERN_READER_DP_EN
    localparam int SEG_W = 8;
`else
    localparam int SEG_W = 7;
`endif
    localparam int SMP_W = NUM_DIGITS + SEG_W;
    localparam logic [SMP_W-1:0] SMP_RST = {{NUM_DIGITS{1'b0}}, {SEG_W{1'b1}}};
    localparam logic [CNT_W-1:0] STB_C   = CNT_W'(STABLE_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_TRACK, S_LOCKED} state_t;

    // Returns {legal, value} for an active-low gfedcba code.
    function automatic logic [4:0] decode_seg(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'b1000000: r = {1'b1, 4'h0};
            7'b1111001: r = {1'b1, 4'h1};
            7'b0100100: r = {1'b1, 4'h2};
            7'b0110000: r = {1'b1, 4'h3};
            7'b0011001: r = {1'b1, 4'h4};
            7'b0010010: r = {1'b1, 4'h5};
            7'b0000010: r = {1'b1, 4'h6};
            7'b1111000: r = {1'b1, 4'h7};
            7'b0000000: r = {1'b1, 4'h8};
            7'b0010000: r = {1'b1, 4'h9};
            7'b0001000: r = {1'b1, 4'hA};
            7'b0000011: r = {1'b1, 4'hB};
            7'b1000110: r = {1'b1, 4'hC};
            7'b0100001: r = {1'b1, 4'hD};
            7'b0000110: r = {1'b1, 4'hE};
            7'b0001110: r = {1'b1, 4'hF};
            default:    r = 5'b0_0000;
        endcase
        return r;
    endfunction

    // Position of the set bit of a one-hot digit select.
    function automatic logic [2:0] sel_index(input logic [NUM_DIGITS-1:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    logic [SMP_W-1:0]      smp_in;
    logic [SMP_W-1:0]      smp_q;
    logic [SMP_W-1:0]      last_q;
    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic [NUM_DIGITS-1:0] sel_q;
    logic [6:0]            seg_q;
    logic                  onehot;
    logic                  changed;

    logic                  acc;
    logic                  acc_blank;
    logic                  acc_legal;
    logic [3:0]            acc_val;
    logic [2:0]            acc_idx;

    logic [3:0]            valor_q;
    logic [2:0]            digito_q;
    logic                  novo_q;
    logic                  apagado_q;
    logic                  erro_q;
    logic [7:0]            err_cnt_q;
    logic [4*NUM_DIGITS-1:0] valores_q;
    logic [NUM_DIGITS-1:0] validos_q;

`ifdef SEG7_PATTERN_READER_DP_EN
    logic                  dp_q;
    logic [NUM_DIGITS-1:0] dps_q;
    assign smp_in = {bus.dig_sel, bus.dp_in, bus.seg_in};
    assign dp_q   = smp_q[7];
`else
    assign smp_in = {bus.dig_sel, bus.seg_in};
`endif

    assign sel_q   = smp_q[SMP_W-1 -: NUM_DIGITS];
    assign seg_q   = smp_q[6:0];
    assign onehot  = $onehot(sel_q);
    assign changed = (smp_q != last_q);

    // State register plus the sample and previous-sample registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            smp_q   <= SMP_RST;
            last_q  <= SMP_RST;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            smp_q   <= smp_in;
            last_q  <= smp_q;
        end
    end

    // Next state: count identical samples, lock once the run is long enough.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!onehot) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else if (state_q == S_LOCKED && !changed) begin
            state_d = S_LOCKED;
            cnt_d   = cnt_q;
        end else begin
            cnt_d   = (state_q == S_TRACK && !changed) ? cnt_q + CNT_W'(1) : CNT_W'(1);
            state_d = (cnt_d == STB_C) ? S_LOCKED : S_TRACK;
        end
    end

    // Acceptance strobe and classification of the sample being accepted.
    always_comb begin
        acc       = (state_d == S_LOCKED) && !(state_q == S_LOCKED && !changed);
        acc_blank = (seg_q == 7'b1111111);
        acc_legal = decode_seg(seg_q)[4];
        acc_val   = decode_seg(seg_q)[3:0];
        acc_idx   = sel_index(sel_q);
    end

    // Registered report outputs, updated on each acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            valor_q   <= '0;
            digito_q  <= '0;
            novo_q    <= 1'b0;
            apagado_q <= 1'b0;
            erro_q    <= 1'b0;
            err_cnt_q <= '0;
            valores_q <= '0;
            validos_q <= '0;
`ifdef SEG7_PATTERN_READER_DP_EN
            dps_q     <= '0;
`endif
        end else begin
            novo_q    <= 1'b0;
            apagado_q <= 1'b0;
            erro_q    <= 1'b0;
            if (acc) begin
                if (acc_blank) begin
                    apagado_q <= 1'b1;
                    validos_q <= validos_q & ~sel_q;
                end else if (acc_legal) begin
                    novo_q    <= 1'b1;
                    valor_q   <= acc_val;
                    digito_q  <= acc_idx;
                    validos_q <= validos_q | sel_q;
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        if (sel_q[i]) valores_q[4*i +: 4] <= acc_val;
                    end
                end else begin
                    erro_q    <= 1'b1;
                    validos_q <= validos_q & ~sel_q;
                    if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
                end
`ifdef SEG7_PATTERN_READER_DP_EN
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (sel_q[i]) dps_q[i] <= ~dp_q;
                end
`endif
            end
        end
    end

    assign bus.valor     = valor_q;
    assign bus.digito    = digito_q;
    assign bus.novo      = novo_q;
    assign bus.apagado   = apagado_q;
    assign bus.erro      = erro_q;
    assign bus.err_count = err_cnt_q;
    assign bus.valores   = valores_q;
    assign bus.validos   = validos_q;
`ifdef SEG7_PATTERN_READER_DP_EN
    assign bus.dps       = dps_q;
`endif

endmodule

// File: tb/tb_seg7_pattern_reader.sv
// Testbench for seg7_pattern_reader: directed scenarios followed by random
// segment/digit traffic, all compared cycle by cycle against a run-length
// reference model of the reader.
module tb_seg7_pattern_reader;
    localparam int ND  = 4;
    localparam int STB = 4;

    typedef struct packed {
        logic [3:0]  valor;
        logic [2:0]  digito;
        logic        novo;
        logic        apagado;
        logic        erro;
        logic [7:0]  err_count;
        logic [15:0] valores;
        logic [3:0]  validos;
`ifdef SEG7_PATTERN_READER_DP_EN
        logic [3:0]  dps;
`endif
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seg7_pattern_reader_if #(.NUM_DIGITS(ND)) bus ();

    seg7_pattern_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(STB), .CNT_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [6:0] lut [16];
    exp_t m;          // model registers
    exp_t cur;        // outputs expected after the coming edge
    int   run;
    logic [3:0] prev_sel;
    logic [6:0] prev_seg;
    logic       prev_dp;
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   novo_seen, apag_seen, erro_seen, step_no, novo_at;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total_cnt++;
        assert (obs === expv) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: drive, advance the model, compare the previous prediction.
    task automatic step(input logic [3:0] sel, input logic [6:0] seg, input logic dp, input logic rst);
        exp_t nx;
        logic same;
        int   v;
        bus.dig_sel = sel;
        bus.seg_in  = seg;
`ifdef SEG7_PATTERN_READER_DP_EN
        bus.dp_in   = dp;
`endif
        reset = rst;
        if (rst) begin
            m   = '0;
            run = 0;
            cur = '0;
            nx  = '0;
        end else begin
            m.novo = 1'b0; m.apagado = 1'b0; m.erro = 1'b0;
`ifdef SEG7_PATTERN_READER_DP_EN
            same = (sel == prev_sel) && (seg == prev_seg) && (dp == prev_dp);
`else
            same = (sel == prev_sel) && (seg == prev_seg);
`endif
            if (!$onehot(sel)) run = 0;
            else if (run > 0 && same) run++;
            else run = 1;
            if (run == STB) begin
                v = -1;
                for (int k = 0; k < 16; k++) if (lut[k] == seg) v = k;
                for (int d = 0; d < ND; d++) begin
                    if (sel[d]) begin
                        if (seg == 7'h7F) begin
                            m.apagado = 1'b1;
                            m.validos[d] = 1'b0;
                        end else if (v >= 0) begin
                            m.novo = 1'b1;
                            m.valor = 4'(v);
                            m.digito = 3'(d);
                            m.valores[4*d +: 4] = 4'(v);
                            m.validos[d] = 1'b1;
                        end else begin
                            m.erro = 1'b1;
                            m.validos[d] = 1'b0;
                            if (m.err_count < 8'd255) m.err_count = m.err_count + 8'd1;
                        end
`ifdef SEG7_PATTERN_READER_DP_EN
                        m.dps[d] = ~dp;
`endif
                    end
                end
            end
            nx = m;
        end
        prev_sel = sel;
        prev_seg = seg;
        prev_dp  = dp;
        @(posedge clk);
        #1;
        chk("valor",     32'(bus.valor),     32'(cur.valor));
        chk("digito",    32'(bus.digito),    32'(cur.digito));
        chk("novo",      32'(bus.novo),      32'(cur.novo));
        chk("apagado",   32'(bus.apagado),   32'(cur.apagado));
        chk("erro",      32'(bus.erro),      32'(cur.erro));
        chk("err_count", 32'(bus.err_count), 32'(cur.err_count));
        chk("valores",   32'(bus.valores),   32'(cur.valores));
        chk("validos",   32'(bus.validos),   32'(cur.validos));
`ifdef SEG7_PATTERN_READER_DP_EN
        chk("dps",       32'(bus.dps),       32'(cur.dps));
`endif
        step_no++;
        if (bus.novo) begin
            novo_seen++;
            if (novo_at == 0) novo_at = step_no;
        end
        if (bus.apagado) apag_seen++;
        if (bus.erro) erro_seen++;
        cur = nx;
    endtask

    task automatic clr_counts();
        novo_seen = 0; apag_seen = 0; erro_seen = 0; step_no = 0; novo_at = 0;
    endtask

    initial begin
        lut = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        m = '0; cur = '0; run = 0;
        prev_sel = '0; prev_seg = 7'h7F; prev_dp = 1'b1;
        clr_counts();

        // Reset state
        step(4'b0000, 7'h7F, 1'b1, 1'b1);
        step(4'b0000, 7'h7F, 1'b1, 1'b1);

        // Digit 0 shows "2" for 10 cycles
        clr_counts();
        repeat (10) step(4'b0001, 7'b0100100, 1'b1, 1'b0);
        chk("t1_novo_cnt", novo_seen, 1);
        chk("t1_latency", novo_at, STB + 1);
        chk("t1_valores", 32'(bus.valores[3:0]), 32'h2);
        chk("t1_validos", 32'(bus.validos), 32'b0001);

        // Glitch before lock on digit 1
        step(4'b0000, 7'h7F, 1'b1, 1'b1);
        clr_counts();
        repeat (2) step(4'b0010, 7'b0100100, 1'b1, 1'b0);
        step(4'b0010, 7'b0110000, 1'b1, 1'b0);
        repeat (3) step(4'b0010, 7'b0100100, 1'b1, 1'b0);
        chk("t2_early_novo", novo_seen, 0);
        repeat (4) step(4'b0010, 7'b0100100, 1'b1, 1'b0);
        chk("t2_novo_cnt", novo_seen, 1);
        chk("t2_valor", 32'(bus.valor), 32'h2);

        // Scan 0,A,b,F across four digits
        step(4'b0000, 7'h7F, 1'b1, 1'b1);
        clr_counts();
        repeat (8) step(4'b0001, 7'b1000000, 1'b1, 1'b0);
        repeat (8) step(4'b0010, 7'b0001000, 1'b1, 1'b0);
        repeat (8) step(4'b0100, 7'b0000011, 1'b1, 1'b0);
        repeat (8) step(4'b1000, 7'b0001110, 1'b1, 1'b0);
        chk("t3_valores", 32'(bus.valores), 32'hFBA0);
        chk("t3_validos", 32'(bus.validos), 32'b1111);
        chk("t3_novo_cnt", novo_seen, 4);
        chk("t3_err", 32'(bus.err_count), 32'd0);

        // Illegal then blank on digit 2
        clr_counts();
        repeat (6) step(4'b0100, 7'b0101010, 1'b1, 1'b0);
        chk("t4_erro_cnt", erro_seen, 1);
        chk("t4_err", 32'(bus.err_count), 32'd1);
        chk("t4_valid2", 32'(bus.validos[2]), 32'd0);
        repeat (6) step(4'b0100, 7'b1111111, 1'b1, 1'b0);
        chk("t4_apag_cnt", apag_seen, 1);
        chk("t4_valid2b", 32'(bus.validos[2]), 32'd0);

        // Two digits selected at once: nothing accepted
        clr_counts();
        repeat (20) step(4'b0011, 7'b1111001, 1'b1, 1'b0);
        chk("t5_pulses", novo_seen + apag_seen + erro_seen, 0);

        // Reset in the middle of tracking
        repeat (2) step(4'b0001, 7'b1111000, 1'b1, 1'b0);
        step(4'b0001, 7'b1111000, 1'b1, 1'b1);
        repeat (6) step(4'b0001, 7'b1111000, 1'b1, 1'b0);

        // 300 illegal acceptances saturate the error counter
        for (int k = 0; k < 300; k++) begin
            repeat (STB) step(4'b0100, (k % 2 == 0) ? 7'b0101010 : 7'b1010101, 1'b1, 1'b0);
        end
        step(4'b0000, 7'h7F, 1'b1, 1'b0);
        step(4'b0000, 7'h7F, 1'b1, 1'b0);
        chk("t5_err_sat", 32'(bus.err_count), 32'd255);

`ifdef SEG7_PATTERN_READER_DP_EN
        // Decimal point toggle after lock
        step(4'b0000, 7'h7F, 1'b1, 1'b1);
        clr_counts();
        repeat (6) step(4'b0001, 7'b1000000, 1'b1, 1'b0);
        repeat (6) step(4'b0001, 7'b1000000, 1'b0, 1'b0);
        chk("t6_novo_cnt", novo_seen, 2);
        chk("t6_dps0", 32'(bus.dps[0]), 32'd1);
`endif

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            logic [3:0] rsel;
            logic [6:0] rseg;
            logic       rdp;
            int         r;
            r = $urandom_range(0, 9);
            if (r < 6) rseg = lut[$urandom_range(0, 15)];
            else if (r < 8) rseg = 7'h7F;
            else rseg = 7'($urandom);
            r = $urandom_range(0, 9);
            if (r < 8) rsel = 4'b0001 << $urandom_range(0, 3);
            else rsel = 4'($urandom);
            rdp = 1'($urandom);
            if ($urandom_range(0, 29) == 0) begin
                step(rsel, rseg, rdp, 1'b1);
            end else begin
                repeat ($urandom_range(1, 8)) step(rsel, rseg, rdp, 1'b0);
            end
        end
        repeat (3) step(4'b0000, 7'h7F, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/seg7_pattern_reader.md
Name: seg7_pattern_reader

Overview:
- Receiving end of the 7-segment display interface: samples an active-low gfedcba segment bus driven per digit (DE2 convention, 0 = segment lit) and recovers the 4-bit hex value shown on each digit.
- Used to loop back and self-check display drivers on board, and as a bench monitor.
- Filters glitches with a stability counter and holds one decoded register per digit.
- Flags blank and illegal patterns.

Parameters:
- NUM_DIGITS, 4, number of digit lanes tracked (1..8).
- STABLE_CYCLES, 4, consecutive identical samples required before a pattern is accepted (>=1).
- CNT_W, 3, width of the stability counter; must satisfy 2^CNT_W > STABLE_CYCLES.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- seg_in  in  7  observed segment bus, gfedcba, active-low.
- dig_sel  in  NUM_DIGITS  one-hot, active-high: which digit seg_in currently drives.
- valor  out  4  most recently accepted decoded value.
- digito  out  3  index of the digit valor belongs to.
- novo  out  1  one-cycle pulse: valor/digito updated with a legal hex pattern.
- apagado  out  1  one-cycle pulse: blank pattern (7'b1111111) accepted.
- erro  out  1  one-cycle pulse: illegal pattern accepted.
- err_count  out  8  saturating count of erro pulses.
- valores  out  4*NUM_DIGITS  per-digit decoded registers; digit i at [4i+3:4i].
- validos  out  NUM_DIGITS  per-digit valid bits.

Behaviour:
- Reset (synchronous): all outputs 0; state IDLE; sample register 7'b1111111; counter 0.
- Legal codes (active-low gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Blank = 1111111. Any other pattern is illegal.
- A sample is the pair {dig_sel, seg_in} registered each cycle.
- State machine:
  - IDLE: dig_sel not exactly one-hot (zero or multiple bits set). Counter held at 0, nothing accepted. Goes to TRACK when dig_sel becomes one-hot.
  - TRACK: counter increments while the sample equals the previous sample; any change resets counter to 1 and stays in TRACK. When the counter reaches STABLE_CYCLES, accept in that same cycle and go to LOCKED.
  - LOCKED: no re-acceptance while the sample is unchanged. Any change goes to TRACK with counter=1. Non-one-hot dig_sel goes to IDLE from any state.
- Accept actions (outputs registered, visible the cycle after the accepting edge):
  - Legal pattern: valores[digit] <= decoded value; validos[digit] <= 1; valor/digito updated; novo=1.
  - Blank: validos[digit] <= 0; valores unchanged; apagado=1.
  - Illegal: validos[digit] <= 0; erro=1; err_count += 1, saturating at 255.
- Latency: a pattern stable from cycle t is reported at t+STABLE_CYCLES+1.
- novo, apagado and erro are mutually exclusive. Each is high for at most one cycle per acceptance.
- A pattern held indefinitely reports exactly once.
- Digit index = position of the set bit in dig_sel. Multiplexed scanning with per-digit dwell >= STABLE_CYCLES+1 fills all lanes.
- Reset asserted mid-TRACK discards the partial count; mid-pulse, the pulse is cleared that cycle.

Optional Feature:
- Macro SEG7_PATTERN_READER_DP_EN.
- Defined:
  - Adds input dp_in (1, active-low decimal point, sampled with seg_in, part of stability compare).
  - Adds output dps (NUM_DIGITS): dps[digit] <= ~dp_in on any acceptance (legal, blank or illegal).
  - A dp_in toggle with unchanged segments counts as a change and causes re-acceptance.
- Undefined: ports absent; decimal point ignored.

Test Plan:
- Reset, then dig_sel=0001, seg_in=0100100 held 10 cycles -> single novo pulse at cycle 5 after first sample; valor=2, digito=0, valores[3:0]=2, validos=0001.
- Pattern glitches 0100100 -> 0110000 for 1 cycle, back to 0100100, all before lock -> counter restarts, no acceptance until 4 clean cycles; final novo with valor=2 only.
- Scan digits 0..3 with 8-cycle dwell showing 0,A,b,F -> valores=16'hFBA0, validos=1111, 4 novo pulses, err_count=0.
- Digit 2 shows 0101010 (illegal) for 6 cycles -> one erro pulse, err_count=1, validos[2]=0; then 1111111 -> apagado pulse, validos[2] stays 0.
- dig_sel=0011 for 20 cycles -> stays IDLE, no pulses; 300 illegal acceptances -> err_count saturates at 255.
- DP_EN build: seg_in=1000000 held, dp_in toggles 1->0 after lock -> second novo, dps[0]=1; assert reset mid-TRACK -> all outputs 0 next cycle.
